// File: rtl/dmem_responder_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and the SRAM responder (slave).
// Signal names follow the initiator side, so _o are slave inputs and _i are slave outputs.
interface dmem_responder_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM behind a req/gnt/rvalid slave port with programmable
// grant wait states and a fixed-latency in-order response pipeline.
module dmem_responder #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned GNT_WAIT = 0,
    parameter int unsigned RESP_LAT = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    dmem_responder_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [31:0]                mem_q [DEPTH];
    logic [IdxW-1:0]            idx;
    logic                       gnt;
    logic                       accept;
    logic [RESP_LAT-1:0]        vld_q, vld_d;
    logic [RESP_LAT-1:0][31:0]  dat_q, dat_d;

    // Upper address bits alias onto the array.
    assign idx    = bus.data_addr_o[IdxW+1:2];
    assign accept = bus.data_req_o & gnt;

    if (GNT_WAIT == 0) begin : g_no_wait
        assign gnt = bus.data_req_o & rst_ni;
    end else begin : g_wait
        localparam int unsigned CntW = (GNT_WAIT > 1) ? $clog2(GNT_WAIT) : 1;

        typedef enum logic [0:0] {StIdle, StWait} state_e;

        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (bus.data_req_o) begin
                        state_d = StWait;
                        cnt_d   = CntW'(GNT_WAIT - 1);
                    end
                end
                StWait: begin
                    // Dropping req before the grant abandons the request silently.
                    if (!bus.data_req_o) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign gnt = (state_q == StWait) && (cnt_q == '0) && bus.data_req_o;
    end

    // Array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (accept && bus.data_we_o) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.data_be_o[n]) begin
                    mem_q[idx][8*n +: 8] <= bus.data_wdata_o[8*n +: 8];
                end
            end
        end
    end

    // Write acks carry zero data so the output mux only needs the valid bit.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int i = RESP_LAT - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        vld_d[0] = accept;
        dat_d[0] = (accept && !bus.data_we_o) ? mem_q[idx] : 32'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign bus.data_gnt_i    = gnt;
    assign bus.data_rvalid_i = vld_q[RESP_LAT-1];
    assign bus.data_rdata_i  = vld_q[RESP_LAT-1] ? dat_q[RESP_LAT-1] : 32'h0;

    addr_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.data_req_o |-> !$isunknown(bus.data_addr_o));
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four parameterisations, directed spec scenarios with literal
// expectations, then randomized traffic against a per-instance transaction-level model.
module tb_dmem_responder;
    localparam int NC = 4;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        bit          known;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0] rst_n, req_s, we_s, gnt_s, rv_s;
    logic [31:0]   addr_s  [NC];
    logic [31:0]   wdata_s [NC];
    logic [31:0]   rd_s    [NC];
    logic [3:0]    be_s    [NC];
    bit   [NC-1:0] acc;
    int            rst_cnt [NC];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req_s[k]   = r;
        we_s[k]    = w;
        addr_s[k]  = a;
        wdata_s[k] = d;
        be_s[k]    = b;
    endtask

    for (genvar g = 0; g < NC; g++) begin : g_inst
        localparam int unsigned Depth   = (g == 0) ? 1024 : 16;
        localparam int unsigned GntWait = (g == 2) ? 2 : 0;
        localparam int unsigned RespLat = (g == 1) ? 2 : (g == 3) ? 3 : 1;
        localparam int unsigned IdxW    = $clog2(Depth);

        dmem_responder_if bus ();

        assign bus.data_req_o   = req_s[g];
        assign bus.data_we_o    = we_s[g];
        assign bus.data_addr_o  = addr_s[g];
        assign bus.data_wdata_o = wdata_s[g];
        assign bus.data_be_o    = be_s[g];
        assign gnt_s[g]         = bus.data_gnt_i;
        assign rv_s[g]          = bus.data_rvalid_i;
        assign rd_s[g]          = bus.data_rdata_i;

        dmem_responder #(
            .DEPTH   (Depth),
            .GNT_WAIT(GntWait),
            .RESP_LAT(RespLat)
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n[g]),
            .bus   (bus)
        );

        // Model: gnt once req has been held GntWait cycles; each accept queues a response
        // due RespLat cycles later; memory tracked per byte with a known mask.
        logic [31:0] mem [Depth];
        bit   [3:0]  kn  [Depth];
        resp_t       q[$];
        int unsigned held = 0;
        int unsigned cyc  = 0;

        always @(negedge clk) begin
            logic        exp_gnt;
            logic        exp_rv;
            resp_t       r;
            int unsigned idx;
            if (!rst_n[g]) begin
                chk("rst_gnt", g, 32'(gnt_s[g]), 32'h0);
                chk("rst_rvalid", g, 32'(rv_s[g]), 32'h0);
                chk("rst_rdata", g, rd_s[g], 32'h0);
                q.delete();
                held   = 0;
                acc[g] = 1'b0;
            end else begin
                exp_gnt = req_s[g] && (held >= GntWait);
                chk("gnt", g, 32'(gnt_s[g]), 32'(exp_gnt));
                exp_rv = (q.size() != 0) && (q[0].due == cyc);
                chk("rvalid", g, 32'(rv_s[g]), 32'(exp_rv));
                if (exp_rv) begin
                    r = q.pop_front();
                    if (r.known) chk("rdata", g, rd_s[g], r.data);
                end else begin
                    chk("rdata_idle", g, rd_s[g], 32'h0);
                end
                acc[g] = exp_gnt;
                if (exp_gnt) begin
                    idx = 32'(addr_s[g][IdxW+1:2]);
                    if (we_s[g]) begin
                        for (int n = 0; n < 4; n++) begin
                            if (be_s[g][n]) begin
                                mem[idx][8*n +: 8] = wdata_s[g][8*n +: 8];
                                kn[idx][n]         = 1'b1;
                            end
                        end
                        r = '{due: cyc + RespLat, data: 32'h0, known: 1'b1};
                    end else begin
                        r = '{due: cyc + RespLat, data: mem[idx], known: (kn[idx] == 4'hF)};
                    end
                    q.push_back(r);
                    held = 0;
                end else begin
                    held = req_s[g] ? held + 1 : 0;
                end
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = '1;
        for (int k = 0; k < NC; k++) begin
            drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            rst_cnt[k] = 0;
        end
        #1 rst_n = '0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);   // gnt must stay low under reset
        repeat (3) tick();
        #2;
        chk("reset_gnt_gated", 0, 32'(gnt_s[0]), 32'h0);
        chk("reset_rvalid", 0, 32'(rv_s[0]), 32'h0);
        req_s[0] = 1'b0;
        rst_n    = '1;
        repeat (2) tick();

        // Basic write then read, zero wait, one-cycle latency.
        drive(0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF);
        #2 chk("basic_wr_gnt", 0, 32'(gnt_s[0]), 32'h1);
        tick();
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
        #2 chk("basic_rd_gnt", 0, 32'(gnt_s[0]), 32'h1);
        chk("basic_wr_ack", 0, 32'(rv_s[0]), 32'h1);
        chk("basic_wr_ack_data", 0, rd_s[0], 32'h0);
        tick();
        req_s[0] = 1'b0;
        #2 chk("basic_rd_rv", 0, 32'(rv_s[0]), 32'h1);
        chk("basic_rd_data", 0, rd_s[0], 32'hDEADBEEF);
        tick();

        // Byte enables.
        drive(0, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        tick();
        drive(0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        tick();
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
        #2 chk("be_merge", 0, rd_s[0], 32'h11BB33DD);
        tick();
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #2 chk("be0_ack", 0, 32'(rv_s[0]), 32'h1);
        tick();
        req_s[0] = 1'b0;
        #2 chk("be0_keep", 0, rd_s[0], 32'h11BB33DD);
        tick();

        // Aliasing: 0x1004 and 0x4 share a word; 0x3 reads word 0 (last written via 0x1000).
        drive(0, 1'b1, 1'b1, 32'h1004, 32'h0000CAFE, 4'hF);
        tick();
        drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h3, 32'h0, 4'h0);
        #2 chk("alias_rd", 0, rd_s[0], 32'h0000CAFE);
        tick();
        req_s[0] = 1'b0;
        #2 chk("addr_lsb_ignored", 0, rd_s[0], 32'hDEADBEEF);
        tick();

        // Back-to-back with two-cycle latency.
        drive(1, 1'b1, 1'b1, 32'h44, 32'h44444444, 4'hF);
        tick();
        req_s[1] = 1'b0;
        repeat (3) tick();
        drive(1, 1'b1, 1'b1, 32'h40, 32'h5, 4'hF);
        #2 chk("b2b_gnt0", 1, 32'(gnt_s[1]), 32'h1);
        tick();
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        #2 chk("b2b_gnt1", 1, 32'(gnt_s[1]), 32'h1);
        chk("b2b_no_rv_yet", 1, 32'(rv_s[1]), 32'h0);
        tick();
        drive(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        #2 chk("b2b_gnt2", 1, 32'(gnt_s[1]), 32'h1);
        chk("b2b_rv0", 1, 32'(rv_s[1]), 32'h1);
        chk("b2b_d0", 1, rd_s[1], 32'h0);
        tick();
        req_s[1] = 1'b0;
        #2 chk("b2b_d1", 1, rd_s[1], 32'h5);
        tick();
        #2 chk("b2b_d2", 1, rd_s[1], 32'h44444444);
        tick();
        #2 chk("b2b_done", 1, 32'(rv_s[1]), 32'h0);
        tick();

        // Two grant wait states.
        drive(2, 1'b1, 1'b1, 32'h8, 32'h77, 4'hF);
        #2 chk("gw_t0", 2, 32'(gnt_s[2]), 32'h0);
        tick();
        #2 chk("gw_t1", 2, 32'(gnt_s[2]), 32'h0);
        tick();
        #2 chk("gw_t2", 2, 32'(gnt_s[2]), 32'h1);
        tick();
        req_s[2] = 1'b0;
        #2 chk("gw_rv", 2, 32'(rv_s[2]), 32'h1);
        tick();
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        #2 chk("gw_drop_t0", 2, 32'(gnt_s[2]), 32'h0);
        tick();
        req_s[2] = 1'b0;
        #2 chk("gw_drop_t1", 2, 32'(gnt_s[2]), 32'h0);
        tick();
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        #2 chk("gw_restart_t0", 2, 32'(gnt_s[2]), 32'h0);
        chk("gw_drop_no_rv", 2, 32'(rv_s[2]), 32'h0);
        tick();
        #2 chk("gw_restart_t1", 2, 32'(gnt_s[2]), 32'h0);
        tick();
        #2 chk("gw_restart_t2", 2, 32'(gnt_s[2]), 32'h1);
        tick();
        req_s[2] = 1'b0;
        #2 chk("gw_rd_data", 2, rd_s[2], 32'h77);
        tick();

        // Reset one cycle after a read accept with three-cycle latency.
        drive(3, 1'b1, 1'b1, 32'h10, 32'hABCD1234, 4'hF);
        tick();
        req_s[3] = 1'b0;
        repeat (4) tick();
        drive(3, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        rst_n[3] = 1'b0;
        #2 chk("mid_rst_gnt", 3, 32'(gnt_s[3]), 32'h0);
        chk("mid_rst_rv", 3, 32'(rv_s[3]), 32'h0);
        chk("mid_rst_rd", 3, rd_s[3], 32'h0);
        tick();
        req_s[3] = 1'b0;
        tick();
        rst_n[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2 chk("post_rst_no_rv", 3, 32'(rv_s[3]), 32'h0);
            tick();
        end
        drive(3, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        req_s[3] = 1'b0;
        tick();
        tick();
        #2 chk("post_rst_rv", 3, 32'(rv_s[3]), 32'h1);
        chk("post_rst_rd", 3, rd_s[3], 32'hABCD1234);
        tick();

        // Randomized traffic, including req drops and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < NC; k++) begin
                if (rst_cnt[k] != 0) begin
                    rst_cnt[k]--;
                    if (rst_cnt[k] == 0) rst_n[k] = 1'b1;
                end else if ($urandom_range(0, 199) == 0) begin
                    rst_n[k]   = 1'b0;
                    req_s[k]   = 1'b0;
                    rst_cnt[k] = int'($urandom_range(1, 3));
                end else if (req_s[k] && !acc[k]) begin
                    if ($urandom_range(0, 15) == 0) req_s[k] = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    drive(k, 1'b1, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_F03F,
                          $urandom(), 4'($urandom_range(0, 15)));
                end else begin
                    req_s[k] = 1'b0;
                end
            end
        end
        tick();
        for (int k = 0; k < NC; k++) begin
            req_s[k] = 1'b0;
            rst_n[k] = 1'b1;
        end
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
